// File: rtl/avmm_rw_responder.sv
// Avalon-MM memory responder: 64-bit word memory with byte-lane writes,
// fixed-latency pipelined reads, sticky access-error flag and
// saturating request counters. Never back-pressures the initiator.
module avmm_rw_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter logic [63:0] BASE_ADDR    = 64'h0,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [63:0] avmm_address,
   input  logic [7:0]  avmm_byteenable,
   input  logic        avmm_read,
   input  logic        avmm_write,
   input  logic [63:0] avmm_writedata,
   output logic [63:0] avmm_readdata,
   output logic        avmm_readdatavalid,
   output logic        err_access,
   input  logic        err_clear,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned BE_W   = 8;
   localparam int unsigned LANE_W = 8;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Storage is deliberately not reset so contents survive resetn.
   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   logic [63:0]       offset_c;
   logic [63:0]       word_c;
   logic [IDX_W-1:0]  idx_c;
   logic              addr_ok_c;
   logic              err_new_c;
   logic              head_v_c;
   logic [DATA_W-1:0] head_d_c;
   logic              tail_v_c;
   logic [DATA_W-1:0] tail_d_c;

   // Address decode: word index relative to BASE_ADDR plus range/alignment check
   always_comb begin
      offset_c  = avmm_address - BASE_ADDR;
      word_c    = offset_c >> 3;
      idx_c     = word_c[IDX_W-1:0];
      addr_ok_c = (avmm_address >= BASE_ADDR) &&
                  (avmm_address[2:0] == 3'b000) &&
                  (word_c < 64'(DEPTH_WORDS));
      err_new_c = (avmm_read || avmm_write) && !addr_ok_c;
   end

   // Read launch: memory is sampled before this edge's write lands (read-before-write)
   always_comb begin
      head_v_c = avmm_read;
      head_d_c = addr_ok_c ? mem[idx_c] : '0;
   end

   // Byte-lane write into storage; invalid addresses never touch memory
   always_ff @(posedge clock) begin
      if (avmm_write && addr_ok_c) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (avmm_byteenable[i]) begin
               mem[idx_c][LANE_W*i +: LANE_W] <= avmm_writedata[LANE_W*i +: LANE_W];
            end
         end
      end
   end

   // Latency pipeline: READ_LATENCY-1 stages ahead of the output register
   if (READ_LATENCY <= 1) begin : g_lat1
      always_comb begin
         tail_v_c = head_v_c;
         tail_d_c = head_d_c;
      end
   end else begin : g_pipe
      localparam int unsigned STAGES = READ_LATENCY - 1;
      localparam int unsigned PIPE_W = STAGES * DATA_W;

      logic [STAGES-1:0]             stage_v;
      logic [STAGES-1:0][DATA_W-1:0] stage_d;

      // Shift valid/data one stage per cycle; reset drops all in-flight reads
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            stage_v <= '0;
            stage_d <= '0;
         end else begin
            stage_v <= STAGES'({stage_v, head_v_c});
            stage_d <= PIPE_W'({stage_d, head_d_c});
         end
      end

      // Oldest stage feeds the output register
      always_comb begin
         tail_v_c = stage_v[STAGES-1];
         tail_d_c = stage_d[STAGES-1];
      end
   end

   // Response register: strobe every cycle, data held between responses
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         avmm_readdatavalid <= 1'b0;
         avmm_readdata      <= '0;
      end else begin
         avmm_readdatavalid <= tail_v_c;
         if (tail_v_c) begin
            avmm_readdata <= tail_d_c;
         end
      end
   end

   // Sticky error flag; a new error wins over a same-cycle clear
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err_access <= 1'b0;
      end else if (err_new_c) begin
         err_access <= 1'b1;
      end else if (err_clear) begin
         err_access <= 1'b0;
      end
   end

   // Saturating request counters, valid and invalid requests alike
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (avmm_read && (rd_count != CNT_MAX)) begin
            rd_count <= rd_count + CNT_W'(1);
         end
         if (avmm_write && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_avmm_rw_responder.sv
// Bench for avmm_rw_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_avmm_rw_responder;

   localparam int unsigned DEPTH = 64;
   localparam logic [63:0] BASE  = 64'h1000;
   localparam int unsigned LAT   = 3;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [63:0] avmm_address = '0;
   logic [7:0]  avmm_byteenable = '0;
   logic        avmm_read = 1'b0;
   logic        avmm_write = 1'b0;
   logic [63:0] avmm_writedata = '0;
   logic [63:0] avmm_readdata;
   logic        avmm_readdatavalid;
   logic        err_access;
   logic        err_clear = 1'b0;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   always #5 clock = ~clock;

   avmm_rw_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .READ_LATENCY(LAT)
   ) dut (
      .clock             (clock),
      .resetn            (resetn),
      .avmm_address      (avmm_address),
      .avmm_byteenable   (avmm_byteenable),
      .avmm_read         (avmm_read),
      .avmm_write        (avmm_write),
      .avmm_writedata    (avmm_writedata),
      .avmm_readdata     (avmm_readdata),
      .avmm_readdatavalid(avmm_readdatavalid),
      .err_access        (err_access),
      .err_clear         (err_clear),
      .rd_count          (rd_count),
      .wr_count          (wr_count)
   );

   int checks = 0;
   int errors = 0;
   bit go = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int unsigned due;
      logic [63:0] data;
   } resp_t;

   logic [63:0] mmem [DEPTH];
   resp_t       rq [$];
   int unsigned ec = 0;
   logic        m_valid = 1'b0;
   logic [63:0] m_data = '0;
   logic        m_err = 1'b0;
   logic [31:0] m_rd = '0;
   logic [31:0] m_wr = '0;
   bit          m_ok;
   int unsigned m_idx;

   function automatic bit addr_ok(input logic [63:0] a);
      if (a < BASE) return 1'b0;
      if ((a % 64'd8) != 64'd0) return 1'b0;
      return ((a - BASE) / 64'd8) < 64'(DEPTH);
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rq.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_err   = 1'b0;
         m_rd    = '0;
         m_wr    = '0;
      end else begin
         ec++;
         m_ok  = addr_ok(avmm_address);
         m_idx = m_ok ? int'((avmm_address - BASE) / 64'd8) : 0;
         if (avmm_read) begin
            rq.push_back('{due: ec + LAT - 1, data: (m_ok ? mmem[m_idx] : 64'h0)});
            if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
         end
         if (avmm_write) begin
            if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
            if (m_ok) begin
               for (int b = 0; b < 8; b++) begin
                  if (avmm_byteenable[b]) mmem[m_idx][8*b +: 8] = avmm_writedata[8*b +: 8];
               end
            end
         end
         if ((avmm_read || avmm_write) && !m_ok) m_err = 1'b1;
         else if (err_clear) m_err = 1'b0;
         m_valid = 1'b0;
         if (rq.size() > 0 && rq[0].due == ec) begin
            m_valid = 1'b1;
            m_data  = rq[0].data;
            void'(rq.pop_front());
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (go) begin
         chk("cyc_valid", 64'(avmm_readdatavalid), 64'(m_valid));
         chk("cyc_readdata", avmm_readdata, m_data);
         chk("cyc_err", 64'(err_access), 64'(m_err));
         chk("cyc_rd_count", 64'(rd_count), 64'(m_rd));
         chk("cyc_wr_count", 64'(wr_count), 64'(m_wr));
      end
   end

   // Response log for directed timing checks
   int unsigned mon_ec [$];
   logic [63:0] mon_d [$];
   always @(negedge clock) begin
      if (avmm_readdatavalid) begin
         mon_ec.push_back(ec);
         mon_d.push_back(avmm_readdata);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wd, input logic clr);
      @(posedge clock);
      #2;
      avmm_read       = rd;
      avmm_write      = wr;
      avmm_address    = addr;
      avmm_byteenable = be;
      avmm_writedata  = wd;
      err_clear       = clr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
   endtask

   function automatic logic [63:0] waddr(input int unsigned i);
      return BASE + 64'(8 * i);
   endfunction

   int unsigned ecr;
   logic [63:0] ra;
   int unsigned r;

   initial begin
      // reset state
      repeat (3) @(posedge clock);
      #2;
      chk("rst_valid", 64'(avmm_readdatavalid), 64'h0);
      chk("rst_data", avmm_readdata, 64'h0);
      chk("rst_err", 64'(err_access), 64'h0);
      chk("rst_rd_count", 64'(rd_count), 64'h0);
      chk("rst_wr_count", 64'(wr_count), 64'h0);

      // first write presented together with reset release
      resetn          = 1'b1;
      go              = 1'b1;
      avmm_write      = 1'b1;
      avmm_address    = BASE + 64'h10;
      avmm_byteenable = 8'hFF;
      avmm_writedata  = 64'h1122334455667788;

      // partial-lane write then read (byteenable ignored on read)
      drive(1'b0, 1'b1, BASE + 64'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0);
      drive(1'b1, 1'b0, BASE + 64'h10, 8'h00, 64'h0, 1'b0);
      repeat (LAT) idle();
      #1;
      chk("lane_valid", 64'(avmm_readdatavalid), 64'h1);
      chk("lane_data", avmm_readdata, 64'h11223344AAAAAAAA);
      chk("lane_model", m_data, 64'h11223344AAAAAAAA);
      chk("lane_wr_count", 64'(wr_count), 64'd2);
      chk("lane_rd_count", 64'(rd_count), 64'd1);

      // preload every word with its index
      for (int unsigned i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, waddr(i), 8'hFF, 64'(i), 1'b0);
      // zero byteenable write: counted, no change
      drive(1'b0, 1'b1, waddr(3), 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      idle();

      // back-to-back reads of words 0..7
      mon_ec.delete();
      mon_d.delete();
      drive(1'b1, 1'b0, waddr(0), 8'h00, 64'h0, 1'b0);
      ecr = ec + 1;
      for (int unsigned i = 1; i < 8; i++) drive(1'b1, 1'b0, waddr(i), 8'h00, 64'h0, 1'b0);
      repeat (LAT + 2) idle();
      chk("b2b_count", 64'(mon_ec.size()), 64'd8);
      for (int i = 0; i < 8 && i < mon_ec.size(); i++) begin
         chk("b2b_edge", 64'(mon_ec[i]), 64'(ecr + LAT - 1 + i));
         chk("b2b_data", mon_d[i], 64'(i));
      end

      // read-before-write at word 5, then read the new value
      mon_ec.delete();
      mon_d.delete();
      drive(1'b1, 1'b1, waddr(5), 8'hFF, 64'h55, 1'b0);
      drive(1'b1, 1'b0, waddr(5), 8'h00, 64'h0, 1'b0);
      repeat (LAT + 2) idle();
      chk("rbw_count", 64'(mon_d.size()), 64'd2);
      if (mon_d.size() == 2) begin
         chk("rbw_old", mon_d[0], 64'h5);
         chk("rbw_new", mon_d[1], 64'h55);
      end

      // invalid accesses and error flag behaviour
      chk("err_before", 64'(err_access), 64'h0);
      drive(1'b1, 1'b0, BASE + 64'(DEPTH * 8), 8'hFF, 64'h0, 1'b0);
      repeat (LAT) idle();
      #1;
      chk("oor_valid", 64'(avmm_readdatavalid), 64'h1);
      chk("oor_data", avmm_readdata, 64'h0);
      chk("oor_err", 64'(err_access), 64'h1);
      drive(1'b0, 1'b1, BASE + 64'h3, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0);
      drive(1'b1, 1'b0, waddr(0), 8'h00, 64'h0, 1'b0);
      repeat (LAT) idle();
      #1;
      chk("mis_unchanged", avmm_readdata, 64'h0);
      drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
      idle();
      chk("clr_alone", 64'(err_access), 64'h0);
      drive(1'b1, 1'b0, BASE - 64'h8, 8'h00, 64'h0, 1'b1);
      idle();
      chk("clr_vs_new", 64'(err_access), 64'h1);
      repeat (LAT) idle();

      // reset with a read in flight
      mon_ec.delete();
      mon_d.delete();
      drive(1'b1, 1'b0, waddr(9), 8'h00, 64'h0, 1'b0);
      idle();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      resetn = 1'b1;
      repeat (LAT + 3) idle();
      chk("flush_none", 64'(mon_d.size()), 64'd0);
      chk("flush_rd_count", 64'(rd_count), 64'd0);
      chk("flush_wr_count", 64'(wr_count), 64'd0);
      drive(1'b1, 1'b0, waddr(9), 8'h00, 64'h0, 1'b0);
      repeat (LAT) idle();
      #1;
      chk("persist_valid", 64'(avmm_readdatavalid), 64'h1);
      chk("persist_data", avmm_readdata, 64'd9);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       ra = waddr($urandom_range(0, DEPTH - 1));
         else if (r == 7) ra = waddr($urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 7));
         else if (r == 8) ra = waddr(DEPTH + $urandom_range(0, 100));
         else             ra = BASE - 64'(8 * $urandom_range(1, 4));
         drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), ra,
               8'($urandom), {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
      end
      repeat (LAT + 2) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/avmm_rw_responder.md
AVMM_RW_RESPONDER -- requirements
Module: avmm_rw_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 64-bit memory words.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0, byte address of word 0.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal range 1..4, cycles from read request to data.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port avmm_address  input  64  byte address from initiator.
REQ-007 SHALL have port avmm_byteenable  input  8  write lane enables, bit i = bits 8i+7:8i.
REQ-008 SHALL have port avmm_read  input  1  read request, one per asserted cycle.
REQ-009 SHALL have port avmm_write  input  1  write request, one per asserted cycle.
REQ-010 SHALL have port avmm_writedata  input  64  write data.
REQ-011 SHALL have port avmm_readdata  output  64  read response data.
REQ-012 SHALL have port avmm_readdatavalid  output  1  one-cycle strobe qualifying avmm_readdata.
REQ-013 SHALL have port err_access  output  1  sticky flag: out-of-range or misaligned access seen.
REQ-014 SHALL have port err_clear  input  1  synchronous clear of err_access.
REQ-015 SHALL have port rd_count  output  32  accepted read requests, saturating.
REQ-016 SHALL have port wr_count  output  32  accepted write requests, saturating.

Function
REQ-017 SHALL never stall the initiator; a request is accepted every cycle read or write is high.
REQ-018 SHALL compute word index = (avmm_address - BASE_ADDR) >> 3; access valid only if address >= BASE_ADDR, index < DEPTH_WORDS, address[2:0] == 0.
REQ-019 SHALL, on a valid write, update only lanes with byteenable set, visible to any read accepted in a later cycle.
REQ-020 SHALL treat a write with byteenable 8'h00 as accepted and counted but leave memory unchanged.
REQ-021 SHALL discard invalid writes (no memory change), count them, and set err_access.
REQ-022 SHALL present read data and pulse avmm_readdatavalid exactly READ_LATENCY cycles after the request cycle, fully pipelined (one response per cycle for back-to-back reads, order preserved).
REQ-023 SHALL return 64'h0 with avmm_readdatavalid for an invalid read, count it, and set err_access.
REQ-024 SHALL, when read and write are both high in one cycle, perform both; the read returns pre-write data (read-before-write), including same address.
REQ-025 SHALL hold avmm_readdata at its last returned value when avmm_readdatavalid is low.
REQ-026 SHALL saturate rd_count and wr_count at 32'hFFFFFFFF; a simultaneous read and write increment each by 1.
REQ-027 SHALL give new error priority over err_clear in the same cycle (err_access stays 1).
REQ-028 SHALL ignore avmm_byteenable on reads (full 64-bit word returned).

Reset
REQ-029 SHALL, on resetn low, immediately set avmm_readdata=0, avmm_readdatavalid=0, err_access=0, rd_count=0, wr_count=0, independent of clock.
REQ-030 SHALL flush the read-latency pipeline on reset; reads in flight at reset SHALL produce no response after reset release.
REQ-031 SHALL NOT initialize memory contents on reset; contents persist across reset.
REQ-032 SHALL accept requests from the first rising edge with resetn high.

Verification
REQ-033 Write 0x1122334455667788 be=FF to BASE+0x10, then write 0xAAAAAAAAAAAAAAAA be=0x0F to same, read -> 0x11223344AAAAAAAA after READ_LATENCY cycles, wr_count=2, rd_count=1.
REQ-034 Back-to-back reads of words 0..7 preloaded with index values, READ_LATENCY=3 -> valid high 8 consecutive cycles starting 3 cycles after first read, data 0..7 in order.
REQ-035 Read+write same cycle at word 5 (old 0x5, new 0x55) -> response 0x5; next-cycle read -> 0x55.
REQ-036 Read at BASE+DEPTH_WORDS*8 and write at BASE+0x3 -> read returns 0 with valid, memory unchanged, err_access=1; err_clear alone -> 0; err_clear with new invalid access -> stays 1.
REQ-037 Issue read, assert resetn low before its response cycle, release -> no avmm_readdatavalid pulse, counters 0, prior memory contents still readable.
